reset_sequencer: RTL

Generates staged, ordered resets for downstream clock-domain resets and their reset synchronizers. It holds all outputs asserted for a minimum time and waits for a stable lock (PLL/transceiver) indication. It then releases the outputs one by one, lowest index first, with a fixed gap between them. On lock loss or a software request it re-asserts all outputs. It sits at the top of the reset tree in the `clk` domain; each `reset_out[i]` feeds a per-domain reset synchronizer.

---
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds all reset outputs, waits for a filtered lock,
// then releases outputs lowest index first. Optional lock-loss event counter
// is built only when RST_SEQ_EVENT_CNT_EN is defined.
module reset_sequencer #(
  parameter int NUM_OUTPUTS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int LOCK_FILTER = 4
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic                   lock_in,
  input  logic                   sw_reset_req,
  output logic [NUM_OUTPUTS-1:0] reset_out,
  output logic                   reset_done,
  output logic                   busy,
  output logic [7:0]             reset_event_cnt
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W   = $clog2(STAGE_GAP + 1);
  localparam int LOCK_W  = $clog2(LOCK_FILTER + 1);
  localparam int STAGE_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  localparam logic [HOLD_W-1:0]      HOLD_LAST     = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]       GAP_LAST      = GAP_W'(STAGE_GAP - 1);
  localparam logic [LOCK_W-1:0]      LOCK_FULL     = LOCK_W'(LOCK_FILTER);
  localparam logic [STAGE_W-1:0]     STAGE_LAST    = STAGE_W'(NUM_OUTPUTS - 1);
  localparam logic [NUM_OUTPUTS-1:0] ALL_ONES      = '1;
  localparam logic [NUM_OUTPUTS-1:0] FIRST_RELEASE = ALL_ONES << 1;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e                 state_q,     state_d;
  logic [HOLD_W-1:0]      hold_cnt_q,  hold_cnt_d;
  logic [STAGE_W-1:0]     stage_cnt_q, stage_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q,   gap_cnt_d;
  logic [LOCK_W-1:0]      lock_cnt_q,  lock_cnt_d;
  logic [NUM_OUTPUTS-1:0] reset_out_q, reset_out_d;
  logic                   reset_done_q, reset_done_d;
  logic                   lock_meta_q, lock_s_q;
  logic                   lock_ok_d;
  logic                   lock_lost;

  // Lock filter. The FSM acts on the filter's next value so the release
  // happens on the same edge that lock_ok is reached.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    lock_cnt_d = lock_cnt_q;
    if (!lock_s_q) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_FULL) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end
  end

  assign lock_ok_d = (lock_cnt_d == LOCK_FULL);
  assign lock_lost = !lock_s_q && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    stage_cnt_d  = stage_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    reset_out_d  = reset_out_q;
    reset_done_d = reset_done_q;

    // Software request outranks lock loss; both restart the whole sequence.
    if (sw_reset_req || lock_lost) begin
      state_d      = ST_ASSERT;
      hold_cnt_d   = '0;
      stage_cnt_d  = '0;
      gap_cnt_d    = '0;
      reset_out_d  = ALL_ONES;
      reset_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_q == HOLD_LAST) begin
            if (lock_ok_d) begin
              state_d     = ST_RELEASE;
              reset_out_d = FIRST_RELEASE;
            end else begin
              state_d = ST_WAIT_LOCK;
            end
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok_d) begin
            state_d     = ST_RELEASE;
            reset_out_d = FIRST_RELEASE;
          end
        end
        ST_RELEASE: begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            if (stage_cnt_q == STAGE_LAST) begin
              state_d      = ST_RUN;
              reset_done_d = 1'b1;
            end else begin
              // Released bits shift in from the bottom, so lower indices stay low.
              stage_cnt_d = stage_cnt_q + STAGE_W'(1);
              reset_out_d = reset_out_q << 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= ST_ASSERT;
      hold_cnt_q   <= '0;
      stage_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      reset_out_q  <= ALL_ONES;
      reset_done_q <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the two-flop synchronizer a real two-stage chain.
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      stage_cnt_q  <= stage_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      reset_out_q  <= reset_out_d;
      reset_done_q <= reset_done_d;
      lock_meta_q  <= lock_in;
      lock_s_q     <= lock_meta_q;
    end
  end

  assign reset_out  = reset_out_q;
  assign reset_done = reset_done_q;
  assign busy       = ~reset_done_q;

`ifdef RST_SEQ_EVENT_CNT_EN
  logic [7:0] event_cnt_q, event_cnt_d;

  // Only lock-loss entries count; a coincident software request wins.
  always_comb begin
    event_cnt_d = event_cnt_q;
    if (lock_lost && !sw_reset_req && (event_cnt_q != 8'hFF)) begin
      event_cnt_d = event_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      event_cnt_q <= '0;
    end else begin
      event_cnt_q <= event_cnt_d;
    end
  end

  assign reset_event_cnt = event_cnt_q;
`else
  assign reset_event_cnt = 8'd0;
`endif

endmodule
